ro_puf_pair_core: RTL and testbench
===================================

Name: ro_puf_pair_core

Overview:
- Parametrised successor to the single behavioural ring oscillator: a challenge-driven RO-PUF measurement core for a bank of NUM_RO oscillators.
- For each of RESP_BITS challenge pairs it:
  - enables only the two selected ROs;
  - lets them settle, then counts their rising edges over a fixed clk window;
  - compares the two counts to produce one response bit.
- Sits between the RO bank (drives its enables, samples its outputs) and the PUF key/response logic.

Parameters:
- NUM_RO, 16: number of ring oscillators in the bank. Must be ≥2.
- RESP_BITS, 8: response bits per challenge, which is also the number of pairs measured.
- CNT_W, 16: edge-counter width; counters saturate.
- WINDOW, 4096: clk cycles per counting window.
- SETTLE, 8: clk cycles the pair is enabled before counting starts.
- SEL_W, $clog2(NUM_RO): localparam, RO index width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a measurement; sampled only in IDLE.
- challenge  in  RESP_BITS*2*SEL_W  pair list; pair i: A = bits [i*2*SEL_W +: SEL_W], B = next SEL_W bits.
- ro_in  in  NUM_RO  raw, asynchronous RO outputs.
- ro_en  out  NUM_RO  per-RO enable to the bank.
- busy  out  1  measurement in progress.
- done  out  1  one-cycle pulse when response is valid.
- response  out  RESP_BITS  bit i = 1 iff count(A_i) > count(B_i).
- tie_mask  out  RESP_BITS  bit i = 1 iff pair i tied or was invalid.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - ro_en, busy, done, response, tie_mask, counters and pair index all go to 0.
  - Synchronisers clear.
  - Reset asserted mid-measurement aborts with no done pulse.
- FSM: IDLE -> SETTLE -> COUNT -> CMP -> (SETTLE for the next pair | DONE) -> IDLE.
- IDLE:
  - start=1 latches challenge and clears response and tie_mask.
  - Pair index goes to 0; next state is SETTLE.
  - busy goes high the following cycle.
- SETTLE:
  - Lasts SETTLE cycles.
  - ro_en has exactly bits A and B set; both counters are held at 0.
- COUNT:
  - Lasts WINDOW cycles; ro_en unchanged.
  - Each ro_in bit passes a 2-FF synchroniser, then a rising-edge detector.
  - Each detected edge on the selected A or B increments its counter.
  - Counter saturates at 2^CNT_W-1; no wrap.
- CMP:
  - Lasts 1 cycle; ro_en = 0.
  - Writes response[i] = (cntA > cntB) and tie_mask[i] = (cntA == cntB).
  - If i < RESP_BITS-1: increment i and go to SETTLE. Otherwise go to DONE.
- Invalid pair (A == B, or either index ≥ NUM_RO):
  - SETTLE and COUNT are skipped; ro_en stays 0.
  - CMP writes response[i] = 0 and tie_mask[i] = 1.
- DONE:
  - done = 1 for one cycle; busy is still 1 in that cycle; then IDLE.
- Latency: start to done = 1 + Σ over pairs of (SETTLE + WINDOW + 1) for valid pairs, or 1 for invalid pairs, + 1 cycles.
- Inputs ignored while busy:
  - start while busy is ignored.
  - A challenge change after the latch has no effect.
- Output hold: response and tie_mask hold until the next accepted start or reset.
- Simultaneous events:
  - An edge landing on the last COUNT cycle is counted.
  - Edges in SETTLE and CMP are not counted.

Optional Feature:
- Macro: PUF_MAJORITY_VOTE_EN.
- Defined:
  - Each valid pair is measured 3 times back-to-back; each measurement is SETTLE+COUNT+CMP with counters cleared in between.
  - response[i] = majority of the three cmp results.
  - tie_mask[i] = 1 if any measurement tied or the three cmp results disagree.
  - Latency per valid pair triples.
  - Invalid pairs are unchanged.
- Undefined: single measurement exactly as above.

Decomposition:
- Package puf_pkg holds:
  - state enum {IDLE, SETTLE, COUNT, CMP, DONE};
  - a vote-count localparam (1 or 3, derived from the macro);
  - a function that extracts pair A/B from challenge.
- Sub-module ro_edge_counter, parametrised by CNT_W, one instance for A and one for B. It contains:
  - the 2-FF synchroniser;
  - the rising-edge detector;
  - the saturating counter with clr and cnt_en.
- The selected ro_in bit is muxed into each instance.

Test Plan:
- Basic compare. Config: clk 10 ns, WINDOW=1000, SETTLE=8. RO3 toggles every 20 ns, RO7 every 25 ns; challenge pair0 = (3,7). Expected: cnt ≈250 vs ≈200 (±1), response[0]=1, tie_mask[0]=0; done after 1+1009+1 cycles.
- Reversed pair. Pair (7,3) with the same stimulus -> response[0]=0, tie_mask[0]=0. ro_en is 0x0088 during SETTLE/COUNT and 0 in CMP.
- Tie and invalid. Pair (5,5), then pair (2,9) with both ROs on an identical 25 ns toggle -> tie_mask=2'b11, response=2'b00; pair0 takes 1 cycle and ro_en stays 0 for it.
- Saturation. CNT_W=4, WINDOW=100; RO A toggles every 10 ns, RO B every 40 ns. Expected: cntA sticks at 15 without wrapping; cntB = 12; response=1.
- Reset mid-COUNT. Drop rst_n asynchronously -> ro_en, busy and response go to 0 immediately and no done pulse occurs. A new start after release completes normally. start pulses while busy cause no restart.
- Majority vote (PUF_MAJORITY_VOTE_EN defined). Bench makes measurement 2 of 3 favour B -> response=1 and tie_mask=1; latency equals 3× the single-measurement value.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared state encoding, vote count and challenge-decoding helpers for the RO-PUF pair core.
// PUF_MAJORITY_VOTE_EN selects three measurements per valid pair instead of one.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_CMP,
        ST_DONE
    } state_e;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int VOTES = 3;
`else
    localparam int VOTES = 1;
`endif

    // Challenges are zero-extended to this width before decoding.
    localparam int CHAL_MAX_W = 1024;

    // Returns RO index A (is_b=0) or B (is_b=1) of pair idx.
    function automatic logic [31:0] pair_sel(input logic [CHAL_MAX_W-1:0] chal,
                                             input int idx,
                                             input int sel_w,
                                             input logic is_b);
        logic [31:0] mask;
        mask = (32'h1 << sel_w) - 32'h1;
        return 32'(chal >> ((2 * idx + int'(is_b)) * sel_w)) & mask;
    endfunction

    function automatic logic pair_valid(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input int num_ro);
        return (a != b) && (a < 32'(num_ro)) && (b < 32'(num_ro));
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one async RO output, detects rising edges and counts them (saturating).
// Latency: an RO rising edge reaches the count three clk edges later.
// Backpressure: none; clr wins over cnt_en.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_async,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] cnt
);

    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    always_comb begin
        sync_d = {sync_q[1:0], ro_async};
        // sync_q[1] is the synchronised level, sync_q[2] its previous value
        rise   = sync_q[1] & ~sync_q[2];
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en && rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ro_puf_pair_core.sv
// RO-PUF measurement core: per challenge pair, enable two ROs, settle, count edges, compare (PUF_MAJORITY_VOTE_EN: 3 votes).
// Latency: 1 + sum(valid: VOTES*(SETTLE+WINDOW+1), invalid: 1) + 1 cycles from start to done.
// Backpressure: start and challenge are ignored while busy; results hold until the next accepted start.
module ro_puf_pair_core
    import puf_pkg::*;
#(
    parameter int  NUM_RO    = 16,
    parameter int  RESP_BITS = 8,
    parameter int  CNT_W     = 16,
    parameter int  WINDOW    = 4096,
    parameter int  SETTLE    = 8,
    localparam int SEL_W     = $clog2(NUM_RO)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
    input  logic [NUM_RO-1:0]            ro_in,
    output logic [NUM_RO-1:0]            ro_en,
    output logic                         busy,
    output logic                         done,
    output logic [RESP_BITS-1:0]         response,
    output logic [RESP_BITS-1:0]         tie_mask
);

    localparam int CHAL_W  = RESP_BITS * 2 * SEL_W;
    localparam int IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);
    localparam logic [1:0]       VOTE_LAST   = 2'(VOTES - 1);
    localparam logic [1:0]       VOTE_ALL    = 2'(VOTES);
    localparam logic [1:0]       VOTE_MAJ    = 2'((VOTES + 1) / 2);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [1:0]             vote_q, vote_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [CHAL_W-1:0]      chal_q, chal_d;
    logic [RESP_BITS-1:0]   resp_q, resp_d;
    logic [RESP_BITS-1:0]   tie_q, tie_d;
    logic [1:0]             gt_acc_q, gt_acc_d;
    logic                   tie_acc_q, tie_acc_d;

    logic [CHAL_MAX_W-1:0]  chal_cur, chal_nxt;
    logic [31:0]            nxt_idx;
    logic [31:0]            cur_a, cur_b, nxt_a, nxt_b;
    logic                   cur_ok, nxt_ok;
    logic [SEL_W-1:0]       sel_a, sel_b;
    logic [CNT_W-1:0]       cnt_a, cnt_b;
    logic                   ro_a, ro_b;
    logic                   gt_now, tie_now, tie_any, pair_done;
    logic [1:0]             gt_tot;

    // Current pair comes from the latched challenge; the "next" pair is pair 0 of the
    // live input while idle, otherwise the pair after the current one.
    always_comb begin
        chal_cur = CHAL_MAX_W'(chal_q);
        chal_nxt = (state_q == ST_IDLE) ? CHAL_MAX_W'(challenge) : chal_cur;
        nxt_idx  = (state_q == ST_IDLE) ? 32'd0 : 32'(idx_q) + 32'd1;
        cur_a    = pair_sel(chal_cur, int'(32'(idx_q)), SEL_W, 1'b0);
        cur_b    = pair_sel(chal_cur, int'(32'(idx_q)), SEL_W, 1'b1);
        nxt_a    = pair_sel(chal_nxt, int'(nxt_idx), SEL_W, 1'b0);
        nxt_b    = pair_sel(chal_nxt, int'(nxt_idx), SEL_W, 1'b1);
        cur_ok   = pair_valid(cur_a, cur_b, NUM_RO);
        nxt_ok   = pair_valid(nxt_a, nxt_b, NUM_RO);
        sel_a    = SEL_W'(cur_a);
        sel_b    = SEL_W'(cur_b);
    end

    always_comb begin
        ro_en = '0;
        if ((state_q == ST_SETTLE) || (state_q == ST_COUNT)) begin
            ro_en[sel_a] = 1'b1;
            ro_en[sel_b] = 1'b1;
        end
    end

    assign ro_a = ro_in[sel_a];
    assign ro_b = ro_in[sel_b];

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .ro_async (ro_a),
        .clr      ((state_q != ST_COUNT) && (state_q != ST_CMP)),
        .cnt_en   (state_q == ST_COUNT),
        .cnt      (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .ro_async (ro_b),
        .clr      ((state_q != ST_COUNT) && (state_q != ST_CMP)),
        .cnt_en   (state_q == ST_COUNT),
        .cnt      (cnt_b)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        vote_d    = vote_q;
        tmr_d     = tmr_q;
        chal_d    = chal_q;
        resp_d    = resp_q;
        tie_d     = tie_q;
        gt_acc_d  = gt_acc_q;
        tie_acc_d = tie_acc_q;
        gt_now    = (cnt_a > cnt_b);
        tie_now   = (cnt_a == cnt_b);
        gt_tot    = gt_acc_q + {1'b0, gt_now};
        tie_any   = tie_acc_q | tie_now;
        pair_done = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chal_d    = challenge;
                    resp_d    = '0;
                    tie_d     = '0;
                    idx_d     = '0;
                    vote_d    = '0;
                    tmr_d     = '0;
                    gt_acc_d  = '0;
                    tie_acc_d = 1'b0;
                    state_d   = nxt_ok ? ST_SETTLE : ST_CMP;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_COUNT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_COUNT: begin
                if (tmr_q == WINDOW_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_CMP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_CMP: begin
                if (!cur_ok) begin
                    resp_d[idx_q] = 1'b0;
                    tie_d[idx_q]  = 1'b1;
                    pair_done     = 1'b1;
                end else if (vote_q == VOTE_LAST) begin
                    // Disagreement between votes is flagged like a tie
                    resp_d[idx_q] = (gt_tot >= VOTE_MAJ);
                    tie_d[idx_q]  = tie_any || ((gt_tot != 2'd0) && (gt_tot != VOTE_ALL));
                    vote_d        = '0;
                    gt_acc_d      = '0;
                    tie_acc_d     = 1'b0;
                    pair_done     = 1'b1;
                end else begin
                    vote_d    = vote_q + 2'd1;
                    gt_acc_d  = gt_tot;
                    tie_acc_d = tie_any;
                    state_d   = ST_SETTLE;
                end
                if (pair_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = nxt_ok ? ST_SETTLE : ST_CMP;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            vote_q    <= '0;
            tmr_q     <= '0;
            chal_q    <= '0;
            resp_q    <= '0;
            tie_q     <= '0;
            gt_acc_q  <= '0;
            tie_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vote_q    <= vote_d;
            tmr_q     <= tmr_d;
            chal_q    <= chal_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
            gt_acc_q  <= gt_acc_d;
            tie_acc_q <= tie_acc_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign response = resp_q;
    assign tie_mask = tie_q;

endmodule

// File: tb/tb_ro_puf_pair_core.sv
// Scoreboard bench: stimulus pushes expected response/tie/latency, monitors pop on done.
`timescale 1ns/1ps
module tb_ro_puf_pair_core;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NV = 3;
`else
    localparam int NV = 1;
`endif
    localparam int MEAS   = 8 + 1000 + 1;
    localparam int MEAS_S = 8 + 100 + 1;

    typedef struct {
        logic [1:0] r;
        logic [1:0] t;
        int         lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    logic [15:0] ro;
    int          half [16];

    logic        start_m, busy_m, done_m;
    logic [15:0] chal_m, ro_en_m;
    logic [1:0]  resp_m, tie_m;

    logic        start_s, busy_s, done_s;
    logic [7:0]  chal_s;
    logic [15:0] ro_en_s;
    logic [0:0]  resp_s, tie_s;

    exp_t sb_m[$];
    exp_t sb_s[$];
    exp_t e_m, e_s;
    int   st_m, st_s;
    int   n_vec, n_err;

    ro_puf_pair_core #(.NUM_RO(16), .RESP_BITS(2), .CNT_W(16), .WINDOW(1000), .SETTLE(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_m), .challenge(chal_m), .ro_in(ro),
        .ro_en(ro_en_m), .busy(busy_m), .done(done_m), .response(resp_m), .tie_mask(tie_m)
    );

    ro_puf_pair_core #(.NUM_RO(16), .RESP_BITS(1), .CNT_W(4), .WINDOW(100), .SETTLE(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .challenge(chal_s), .ro_in(ro),
        .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .response(resp_s), .tie_mask(tie_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RO waveforms are a pure function of time; +2 keeps every toggle off both clk edges.
    initial begin
        ro = '0;
        forever begin
            #1;
            for (int j = 0; j < 16; j++) begin
                if (half[j] == 0) ro[j] = 1'b0;
                else ro[j] = (((longint'($time) + 2) / half[j]) % 2) == 1;
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endfunction

    always @(negedge clk) begin
        if (done_m) begin
            if (sb_m.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL main_unexpected_done: got done=1 expected no done");
            end else begin
                e_m = sb_m.pop_front();
                chk("main_response", 32'(resp_m), 32'(e_m.r));
                chk("main_tie_mask", 32'(tie_m), 32'(e_m.t));
                chk("main_latency", 32'(cyc - st_m + 1), 32'(e_m.lat));
                chk("main_busy_at_done", 32'(busy_m), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (done_s) begin
            if (sb_s.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sat_unexpected_done: got done=1 expected no done");
            end else begin
                e_s = sb_s.pop_front();
                chk("sat_response", 32'(resp_s), 32'(e_s.r[0]));
                chk("sat_tie_mask", 32'(tie_s), 32'(e_s.t[0]));
                chk("sat_latency", 32'(cyc - st_s + 1), 32'(e_s.lat));
            end
        end
    end

    task automatic issue(input bit sat, input logic [15:0] chal, input logic [1:0] er,
                         input logic [1:0] et, input int lat, input bit push);
        exp_t e;
        e.r = er;
        e.t = et;
        e.lat = lat;
        @(negedge clk);
        if (sat) begin
            chal_s  = chal[7:0];
            start_s = 1'b1;
            st_s    = cyc;
            if (push) sb_s.push_back(e);
        end else begin
            chal_m  = chal;
            start_m = 1'b1;
            st_m    = cyc;
            if (push) sb_m.push_back(e);
        end
        @(negedge clk);
        start_m = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic wait_done(input bit sat);
        for (int i = 0; i < 5000; i++) begin
            if ((sat ? sb_s.size() : sb_m.size()) == 0) break;
            @(negedge clk);
        end
        if ((sat ? sb_s.size() : sb_m.size()) != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done within 5000 cycles expected done (sat=%0d)", sat);
            if (sat) sb_s.delete();
            else sb_m.delete();
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        rst_n = 1'b1; start_m = 1'b0; start_s = 1'b0; chal_m = '0; chal_s = '0;
        for (int j = 0; j < 16; j++) half[j] = 0;
        half[3] = 20; half[7] = 25; half[2] = 25; half[9] = 25; half[10] = 10; half[11] = 40;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_response", 32'(resp_m), 32'd0);
        chk("rst_tie_mask", 32'(tie_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_done", 32'(done_m), 32'd0);
        chk("rst_ro_en", 32'(ro_en_m), 32'd0);
        chk("rst_sat_busy", 32'(busy_s), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pair0 = (3,7): RO3 40 ns period beats RO7 50 ns period; pair1 = (5,5) invalid
        issue(0, 16'h5573, 2'b01, 2'b10, 1 + NV * MEAS + 1 + 1, 1);
        chk("busy_after_start", 32'(busy_m), 32'd1);
        wait_done(0);
        repeat (20) @(negedge clk);
        chk("hold_response", 32'(resp_m), 32'h1);
        chk("hold_tie_mask", 32'(tie_m), 32'h2);
        chk("idle_busy", 32'(busy_m), 32'd0);

        // Reversed pair and ro_en profile of the first measurement
        issue(0, 16'h5537, 2'b00, 2'b10, 1 + NV * MEAS + 1 + 1, 1);
        chk("rev_ro_en_settle", 32'(ro_en_m), 32'h0088);
        repeat (499) @(negedge clk);
        chk("rev_ro_en_count", 32'(ro_en_m), 32'h0088);
        repeat (509) @(negedge clk);
        chk("rev_ro_en_cmp", 32'(ro_en_m), 32'h0000);
        wait_done(0);

        // Pair0 (5,5) invalid takes one cycle; pair1 (2,9) on identical waveforms ties
        issue(0, 16'h9255, 2'b00, 2'b11, 1 + 1 + NV * MEAS + 1, 1);
        chk("inv_ro_en_cmp", 32'(ro_en_m), 32'h0000);
        @(negedge clk);
        chk("tie_ro_en_settle", 32'(ro_en_m), 32'h0204);
        wait_done(0);

        // Saturation: RO10 gives 50 edges (sticks at 15), RO11 gives 12
        issue(1, 16'h00BA, 2'b01, 2'b00, 1 + NV * MEAS_S + 1, 1);
        wait_done(1);
        issue(1, 16'h00AB, 2'b00, 2'b00, 1 + NV * MEAS_S + 1, 1);
        wait_done(1);

        // Asynchronous reset in the middle of COUNT aborts without done
        issue(0, 16'h5573, 2'b00, 2'b00, 0, 0);
        repeat (300) @(negedge clk);
        chk("mid_busy", 32'(busy_m), 32'd1);
        chk("mid_ro_en", 32'(ro_en_m), 32'h0088);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ro_en", 32'(ro_en_m), 32'd0);
        chk("arst_busy", 32'(busy_m), 32'd0);
        chk("arst_response", 32'(resp_m), 32'd0);
        chk("arst_tie_mask", 32'(tie_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1100) @(negedge clk);
        chk("post_rst_idle", 32'(busy_m), 32'd0);

        // Start and challenge changes while busy must not disturb the latched measurement
        issue(0, 16'h5573, 2'b01, 2'b10, 1 + NV * MEAS + 1 + 1, 1);
        repeat (5) @(negedge clk);
        chal_m  = 16'h5537;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (3) @(negedge clk);
        chal_m = 16'h9255;
        wait_done(0);

`ifdef PUF_MAJORITY_VOTE_EN
        // Second of three measurements has the RO periods swapped so B wins that vote
        issue(0, 16'h5573, 2'b01, 2'b11, 1 + 3 * MEAS + 1 + 1, 1);
        repeat (1011) @(negedge clk);
        half[3] = 25; half[7] = 20;
        repeat (1007) @(negedge clk);
        half[3] = 20; half[7] = 25;
        wait_done(0);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
